pc_fetch_unit: RTL and testbench

Program-counter stage of the single-cycle MIPS datapath. Holds the architectural PC, drives it to the AddFour incrementer and the instruction-memory fetch port, and consumes the incrementer's PC+4 result. Selects the next PC from four sources: sequential, branch, jump, or trap. Supports stall, a one-entry pending-redirect buffer, and misaligned-target trapping.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/next_pc_sel.sv | 77 +++++++
 rtl/pc_fetch_unit.sv | 137 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
//
// Shared definitions for the MIPS datapath blocks.
//   ADDR_W               - width of every instruction address
//   DEFAULT_RESET_VECTOR - PC loaded while reset is asserted
//   DEFAULT_TRAP_VECTOR  - PC loaded when a misaligned redirect target is taken
//   pc_state_t           - fetch-stage sequencing state (BOOT, RUN)
//   is_misaligned()      - true when an address is not word aligned

package mips_pkg;

  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

  // Instructions are 32-bit words, so any target with low bits set cannot
  // be fetched and has to be turned into a trap instead.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel
//
// Purely combinational next-PC selection for the fetch stage.
//
// Ports:
//   pc_plus4    in  - sequential next PC from the external AddFour block
//   br_taken    in  - branch redirect request
//   br_target   in  - branch target
//   jump        in  - jump / jr redirect request (beats br_taken)
//   jump_target in  - jump target
//   pend_v      in  - pending-redirect buffer holds a target
//   pend_tgt    in  - pending-redirect target
//   redir_req   out - a redirect is requested this cycle
//   redir_tgt   out - arbitrated same-cycle redirect target
//   next_pc     out - PC to load if the fetch advances this cycle
//   take_trap   out - selected redirect target is misaligned
//   bad_tgt     out - the misaligned target (meaningful when take_trap=1)

module next_pc_sel
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              pend_v,
  input  logic [ADDR_W-1:0] pend_tgt,
  output logic              redir_req,
  output logic [ADDR_W-1:0] redir_tgt,
  output logic [ADDR_W-1:0] next_pc,
  output logic              take_trap,
  output logic [ADDR_W-1:0] bad_tgt
);

  logic              use_redirect;
  logic [ADDR_W-1:0] chosen_tgt;

  // Jump outranks branch when both fire together; the branch target is
  // simply dropped, not queued behind the jump.
  always_comb begin
    redir_req = jump || br_taken;
    redir_tgt = jump ? jump_target : br_target;
  end

  // Priority: same-cycle redirect, then the pending buffer, then the
  // sequential PC. Only the redirect sources are alignment-checked;
  // pc_plus4 is trusted as delivered by AddFour.
  always_comb begin
    use_redirect = 1'b0;
    chosen_tgt   = pc_plus4;
    next_pc      = pc_plus4;
    take_trap    = 1'b0;
    bad_tgt      = '0;

    if (redir_req) begin
      use_redirect = 1'b1;
      chosen_tgt   = redir_tgt;
    end else if (pend_v) begin
      use_redirect = 1'b1;
      chosen_tgt   = pend_tgt;
    end

    if (use_redirect) begin
      if (is_misaligned(chosen_tgt)) begin
        next_pc   = TRAP_VECTOR;
        take_trap = 1'b1;
        bad_tgt   = chosen_tgt;
      end else begin
        next_pc = chosen_tgt;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//
// Program-counter stage of the single-cycle MIPS datapath. Holds the
// architectural PC, presents it to AddFour and to instruction memory, and
// picks the next PC from sequential, branch, jump or trap sources.
//
// Ports:
//   clk         in  - clock, all state updates on the rising edge
//   rst_n       in  - asynchronous active-low reset
//   pc          out - current PC (AddFour A input and imem address)
//   pc_plus4    in  - AddFour result, the sequential next PC
//   fetch_valid out - fetch request at pc is valid
//   fetch_ready in  - imem accepts the request
//   stall       in  - downstream hold, PC must not advance
//   br_taken    in  - branch redirect request
//   br_target   in  - branch target
//   jump        in  - jump / jr redirect request
//   jump_target in  - jump target
//   trap        out - one-cycle pulse after a misaligned target is taken
//   epc         out - offending target of the most recent trap

module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              trap,
  output logic [ADDR_W-1:0] epc
);

  pc_state_t         state;
  logic              advance;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_tgt;
  logic              redir_req;
  logic [ADDR_W-1:0] redir_tgt;
  logic [ADDR_W-1:0] next_pc;
  logic              take_trap;
  logic [ADDR_W-1:0] bad_tgt;

  // The PC only moves when the stage is running, imem took the request
  // and nothing downstream is holding us.
  always_comb begin
    advance = (state == RUN) && fetch_ready && !stall;
  end

  next_pc_sel #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_pc_sel (
    .pc_plus4    (pc_plus4),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .pend_v      (pend_v),
    .pend_tgt    (pend_tgt),
    .redir_req   (redir_req),
    .redir_tgt   (redir_tgt),
    .next_pc     (next_pc),
    .take_trap   (take_trap),
    .bad_tgt     (bad_tgt)
  );

  // Sequencing: a single BOOT cycle after reset with no fetch request,
  // then RUN forever. fetch_valid is registered alongside the state so it
  // stays glitch-free and holds steady through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetch_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  // Pending-redirect buffer. Any redirect that cannot be honoured this
  // cycle (BOOT, stall or imem not ready) is parked here, newest winning.
  // Every advance empties it: either the same-cycle redirect superseded
  // it, or it was the source of the new PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v   <= 1'b0;
      pend_tgt <= '0;
    end else if (advance) begin
      pend_v <= 1'b0;
    end else if (redir_req) begin
      pend_v   <= 1'b1;
      pend_tgt <= redir_tgt;
    end
  end

  // PC, trap pulse and EPC. trap is cleared every cycle it is not being
  // raised, which makes it a single-cycle pulse; epc keeps the last
  // offending target until the next trap overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_VECTOR;
      trap <= 1'b0;
      epc  <= '0;
    end else begin
      trap <= 1'b0;
      if (advance) begin
        pc <= next_pc;
        if (take_trap) begin
          trap <= 1'b1;
          epc  <= bad_tgt;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//
// Self-checking bench for pc_fetch_unit. A directed sequence walks the
// documented scenarios, then a randomized stretch runs against a simple
// behavioural model of the fetch rules.

module tb_pc_fetch_unit;

  localparam logic [31:0] RST_VEC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0080;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        trap;
  logic [31:0] epc;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_run;
  bit          m_trap;
  bit          m_pend_v;
  logic [31:0] m_pend;

  pc_fetch_unit #(
    .RESET_VECTOR (RST_VEC),
    .TRAP_VECTOR  (TRAP_VEC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .trap        (trap),
    .epc         (epc)
  );

  // AddFour stand-in
  assign pc_plus4 = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    m_pc     = RST_VEC;
    m_epc    = 32'h0;
    m_run    = 0;
    m_trap   = 0;
    m_pend_v = 0;
    m_pend   = 32'h0;
  endtask

  // One clock of the fetch rules, using the inputs seen at the edge
  task automatic modelStep(input bit rdy, input bit st, input bit bt,
                           input logic [31:0] btt, input bit j,
                           input logic [31:0] jt);
    bit          redir;
    logic [31:0] rtgt;
    logic [31:0] tgt;
    bit          use_tgt;
    redir  = j || bt;
    rtgt   = j ? jt : btt;
    m_trap = 0;
    if (m_run && rdy && !st) begin
      use_tgt = 1;
      if (redir)         tgt = rtgt;
      else if (m_pend_v) tgt = m_pend;
      else begin
        use_tgt = 0;
        tgt     = m_pc + 32'd4;
      end
      m_pend_v = 0;
      if (use_tgt && (tgt % 4 != 0)) begin
        m_pc   = TRAP_VEC;
        m_epc  = tgt;
        m_trap = 1;
      end else begin
        m_pc = tgt;
      end
    end else if (redir) begin
      m_pend_v = 1;
      m_pend   = rtgt;
    end
    m_run = 1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".pc"},          pc,                   m_pc);
    checkOutput({tag, ".fetch_valid"}, {31'h0, fetch_valid}, {31'h0, m_run});
    checkOutput({tag, ".trap"},        {31'h0, trap},        {31'h0, m_trap});
    checkOutput({tag, ".epc"},         epc,                  m_epc);
  endtask

  // Drive one cycle of inputs, clock it, advance the model, then check
  task automatic applyStimulus(input string tag, input bit rdy, input bit st,
                               input bit bt, input logic [31:0] btt,
                               input bit j, input logic [31:0] jt);
    fetch_ready = rdy;
    stall       = st;
    br_taken    = bt;
    br_target   = btt;
    jump        = j;
    jump_target = jt;
    @(posedge clk);
    modelStep(rdy, st, bt, btt, j, jt);
    #1;
    checkAll(tag);
  endtask

  task automatic idleInputs();
    fetch_ready = 1'b1;
    stall       = 1'b0;
    br_taken    = 1'b0;
    br_target   = 32'h0;
    jump        = 1'b0;
    jump_target = 32'h0;
  endtask

  initial begin
    logic [31:0] t1;
    logic [31:0] t2;

    // Reset state
    idleInputs();
    rst_n = 1'b0;
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAll("boot_pre");

    // Boot cycle then sequential fetch 0x0, 0x4, 0x8
    applyStimulus("boot",  1, 0, 0, 32'h0, 0, 32'h0);
    applyStimulus("seq4",  1, 0, 0, 32'h0, 0, 32'h0);
    applyStimulus("seq8",  1, 0, 0, 32'h0, 0, 32'h0);

    // Stall hold at 0x8, then release to 0xC
    for (int i = 0; i < 3; i++)
      applyStimulus("stall_hold", 1, 1, 0, 32'h0, 0, 32'h0);
    applyStimulus("stall_rel", 1, 0, 0, 32'h0, 0, 32'h0);

    // imem not ready also holds the PC
    applyStimulus("not_ready", 0, 0, 0, 32'h0, 0, 32'h0);

    // Redirects during stall: newest (jump 0x100) wins
    applyStimulus("st_br",   1, 1, 1, 32'h40, 0, 32'h0);
    applyStimulus("st_jmp",  1, 1, 0, 32'h0,  1, 32'h100);
    applyStimulus("st_rel",  1, 0, 0, 32'h0,  0, 32'h0);

    // Simultaneous jump and branch on advance
    applyStimulus("simul",   1, 0, 1, 32'h300, 1, 32'h200);

    // Misaligned jump traps to 0x80 for one cycle
    applyStimulus("misal",   1, 0, 0, 32'h0, 1, 32'h102);
    applyStimulus("misal_after", 1, 0, 0, 32'h0, 0, 32'h0);

    // Misaligned target parked in pending buffer traps when consumed
    applyStimulus("pmis_st",  1, 1, 1, 32'h0301, 0, 32'h0);
    applyStimulus("pmis_rel", 1, 0, 0, 32'h0,    0, 32'h0);

    // Mid-operation reset with a pending redirect outstanding
    applyStimulus("pre_rst_j",  1, 0, 0, 32'h0,  1, 32'h200);
    applyStimulus("pre_rst_pd", 1, 1, 1, 32'h40, 0, 32'h0);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll("async_rst");
    idleInputs();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("rst_boot", 1, 0, 0, 32'h0, 0, 32'h0);
    applyStimulus("rst_seq4", 1, 0, 0, 32'h0, 0, 32'h0);
    applyStimulus("rst_seq8", 1, 0, 0, 32'h0, 0, 32'h0);

    // Redirect arriving during BOOT is captured and applied later
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("boot_redir", 1, 0, 0, 32'h0, 1, 32'h20);
    applyStimulus("boot_apply", 1, 0, 0, 32'h0, 0, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      t1 = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
      t2 = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) t1 = t1 | $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) t2 = t2 | $urandom_range(1, 3);
      applyStimulus("rand",
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) == 0, t1,
                    $urandom_range(0, 5) == 0, t2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
